// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC sample sequencer.
package dac_pkg;
  typedef enum logic [1:0] {IDLE, PRIME, PLAY} state_t;
  typedef enum logic {SEL_A, SEL_B} sel_t;

  localparam int SAMPLE_W = 10;
  localparam int A_OFFSET = 0;
  localparam int B_OFFSET = 16;
  localparam int MIN_DIV  = 1;
endpackage

// File: rtl/sample_fifo.sv
// Synchronous word FIFO. Full/empty come from read/write pointers that carry one extra wrap bit.
module sample_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [0:WIDTH-1]       wr_data,
  output logic [0:WIDTH-1]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [0:WIDTH-1] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign level   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // A flush wins over any push or pop in the same cycle.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/dac_sample_sequencer.sv
// Playback scheduler: unpacks two samples per buffered word and emits one per
// programmable period, with a DAC latch clock that rises mid-period.
module dac_sample_sequencer #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter int SAMPLE_W   = dac_pkg::SAMPLE_W
) (
  input  logic                        Bus2IP_Clk,
  input  logic                        Bus2IP_Reset,
  input  logic                        Cfg_Enable,
  input  logic                        Cfg_Flush,
  input  logic [DIV_W-1:0]            Cfg_RateDiv,
  input  logic                        Wr_Valid,
  input  logic [0:31]                 Wr_Data,
  output logic                        Wr_Ready,
  input  logic                        Underrun_Clr,
  output logic [0:SAMPLE_W-1]         IP2DAC_Data,
  output logic                        IP2DAC_DCLKIO,
  output logic                        Underrun,
  output logic [$clog2(FIFO_DEPTH):0] Fifo_Level,
  output logic                        Busy
);
  import dac_pkg::*;

  localparam logic [DIV_W:0]   ONE      = (DIV_W+1)'(1);
  localparam logic [DIV_W-1:0] MIN_RATE = DIV_W'(MIN_DIV);

  state_t              state;
  state_t              state_next;
  sel_t                sel;
  logic [DIV_W-1:0]    count;
  logic [DIV_W:0]      period;
  logic [DIV_W:0]      period_cfg;
  logic [0:SAMPLE_W-1] hold_b;
  logic [0:31]         rd_word;
  logic                full;
  logic                empty;
  logic                tick;
  logic                pop;
  logic                show_b;
  logic                set_underrun;
  logic                unused_bits;

  sample_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk     (Bus2IP_Clk),
    .rst     (Bus2IP_Reset),
    .push    (Wr_Valid && Wr_Ready),
    .pop     (pop),
    .flush   (Cfg_Flush),
    .wr_data (Wr_Data),
    .rd_data (rd_word),
    .full    (full),
    .empty   (empty),
    .level   (Fifo_Level)
  );

  assign unused_bits = ^{rd_word[A_OFFSET+SAMPLE_W:B_OFFSET-1], rd_word[B_OFFSET+SAMPLE_W:31]};

  assign Wr_Ready      = !full;
  assign Busy          = (state != IDLE);
  assign period_cfg    = {1'b0, (Cfg_RateDiv < MIN_RATE) ? MIN_RATE : Cfg_RateDiv} + ONE;
  assign tick          = (state == PLAY) && ({1'b0, count} == period - ONE);
  assign IP2DAC_DCLKIO = (state == PLAY) && ({1'b0, count} >= (period >> 1));

  // Disable beats flush, flush beats normal sequencing; an empty FIFO at a B tick is an underrun.
  always_comb begin
    state_next   = state;
    pop          = 1'b0;
    show_b       = 1'b0;
    set_underrun = 1'b0;
    if (!Cfg_Enable) begin
      state_next = IDLE;
    end else if (Cfg_Flush) begin
      state_next = PRIME;
    end else begin
      unique case (state)
        IDLE:  state_next = PRIME;
        PRIME: begin
          if (!empty) begin
            pop        = 1'b1;
            state_next = PLAY;
          end
        end
        PLAY: begin
          if (tick) begin
            if (sel == SEL_A) show_b = 1'b1;
            else if (!empty)  pop = 1'b1;
            else              set_underrun = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
    if (Bus2IP_Reset) begin
      state       <= IDLE;
      sel         <= SEL_A;
      count       <= '0;
      period      <= ONE + ONE;
      hold_b      <= '0;
      IP2DAC_Data <= '0;
      Underrun    <= 1'b0;
    end else begin
      state <= state_next;
      if (state != PLAY || state_next != PLAY || tick) count <= '0;
      else                                             count <= count + DIV_W'(1);
      // The divider is only picked up at a period boundary so a period never changes length.
      if (pop || tick) period <= period_cfg;
      if (Cfg_Flush || pop) sel <= SEL_A;
      else if (show_b)      sel <= SEL_B;
      if (pop) begin
        hold_b      <= rd_word[B_OFFSET +: SAMPLE_W];
        IP2DAC_Data <= rd_word[A_OFFSET +: SAMPLE_W];
      end else if (show_b) begin
        IP2DAC_Data <= hold_b;
      end
      if (Underrun_Clr)      Underrun <= 1'b0;
      else if (set_underrun) Underrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dac_sample_sequencer.sv
// Bench for dac_sample_sequencer: directed and random sample streams checked
// against a slot-level playback model (one sample per period, A before B).
module tb_dac_sample_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        flush;
  logic [15:0] rate;
  logic        wr_valid;
  logic [0:31] wr_data;
  logic        wr_ready;
  logic        ur_clr;
  logic [0:9]  dac_data;
  logic        dclk;
  logic        underrun;
  logic [4:0]  level;
  logic        busy;

  int          checks = 0;
  int          errors = 0;

  // Playback model: t counts cycles from the first sample shown; per is the period.
  int          t;
  int          per;
  logic [9:0]  cur;
  logic [31:0] hold_w;
  bit          half_b;
  bit          u_exp;
  bit          clr_pend;
  logic [31:0] word_q[$];
  int          avail_q[$];

  dac_sample_sequencer dut (
    .Bus2IP_Clk    (clk),
    .Bus2IP_Reset  (rst),
    .Cfg_Enable    (enable),
    .Cfg_Flush     (flush),
    .Cfg_RateDiv   (rate),
    .Wr_Valid      (wr_valid),
    .Wr_Data       (wr_data),
    .Wr_Ready      (wr_ready),
    .Underrun_Clr  (ur_clr),
    .IP2DAC_Data   (dac_data),
    .IP2DAC_DCLKIO (dclk),
    .Underrun      (underrun),
    .Fifo_Level    (level),
    .Busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int model_level(input int tt);
    int n = 0;
    foreach (avail_q[i]) if (avail_q[i] <= tt) n++;
    return n;
  endfunction

  // Each period boundary shows B of the current word, or A of the next word if one
  // had arrived before the boundary cycle; otherwise the last sample repeats and underrun sticks.
  task automatic model_slot();
    if (t == 0 || (t % per) == 0) begin
      if (t == 0 || half_b) begin
        if (word_q.size() > 0 && (t == 0 || avail_q[0] <= t - 1)) begin
          hold_w = word_q.pop_front();
          avail_q.delete(0);
          cur    = hold_w[31:22];
          half_b = 1'b0;
        end else begin
          u_exp = 1'b1;
        end
      end else begin
        cur    = hold_w[15:6];
        half_b = 1'b1;
      end
    end
    if (clr_pend) begin
      u_exp    = 1'b0;
      clr_pend = 1'b0;
    end
  endtask

  task automatic play_cycles(input int count, input int wr_at, input logic [31:0] wr_word, input int clr_at);
    for (int i = 0; i < count; i++) begin
      @(negedge clk);
      model_slot();
      check_output("data", 32'(dac_data), 32'(cur));
      check_output("dclk", 32'(dclk), ((t % per) >= (per / 2)) ? 32'd1 : 32'd0);
      check_output("underrun", 32'(underrun), 32'(u_exp));
      check_output("level", 32'(level), 32'(model_level(t)));
      check_output("busy", 32'(busy), 32'd1);
      wr_valid = (i == wr_at);
      wr_data  = wr_word;
      if (i == wr_at) begin
        word_q.push_back(wr_word);
        avail_q.push_back(t + 1);
      end
      ur_clr = (i == clr_at);
      if (i == clr_at) clr_pend = 1'b1;
      t++;
    end
  endtask

  task automatic fill_word(input logic [31:0] w);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = w;
    word_q.push_back(w);
    avail_q.push_back(-1000);
  endtask

  task automatic end_fill(input int n);
    @(negedge clk);
    wr_valid = 1'b0;
    check_output("fill_level", 32'(level), 32'(n));
  endtask

  task automatic start_play(input int rate_div);
    @(negedge clk);
    rate   = 16'(rate_div);
    per    = ((rate_div < 1) ? 1 : rate_div) + 1;
    enable = 1'b1;
    @(negedge clk);
    check_output("prime_busy", 32'(busy), 32'd1);
    check_output("prime_level", 32'(level), 32'(word_q.size()));
    t      = 0;
    half_b = 1'b0;
  endtask

  task automatic stop_and_flush();
    @(negedge clk);
    model_slot();
    t++;
    enable   = 1'b0;
    flush    = 1'b1;
    ur_clr   = 1'b1;
    wr_valid = 1'b0;
    @(negedge clk);
    flush  = 1'b0;
    ur_clr = 1'b0;
    check_output("stop_busy", 32'(busy), 32'd0);
    check_output("stop_level", 32'(level), 32'd0);
    check_output("stop_underrun", 32'(underrun), 32'd0);
    check_output("stop_dclk", 32'(dclk), 32'd0);
    check_output("stop_data_held", 32'(dac_data), 32'(cur));
    word_q.delete();
    avail_q.delete();
    u_exp    = 1'b0;
    half_b   = 1'b0;
    clr_pend = 1'b0;
  endtask

  initial begin
    int          n;
    int          total;
    int          rd;
    logic [31:0] w;

    rst = 1'b1; enable = 1'b0; flush = 1'b0; rate = '0;
    wr_valid = 1'b0; wr_data = '0; ur_clr = 1'b0;
    per = 2; t = 0; cur = '0; hold_w = '0; half_b = 1'b0; u_exp = 1'b0; clr_pend = 1'b0;

    // Reset state, during and after reset.
    @(negedge clk);
    check_output("rst_data", 32'(dac_data), 32'd0);
    check_output("rst_dclk", 32'(dclk), 32'd0);
    check_output("rst_underrun", 32'(underrun), 32'd0);
    check_output("rst_level", 32'(level), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_ready", 32'(wr_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_output("idle_busy", 32'(busy), 32'd0);
    check_output("idle_ready", 32'(wr_ready), 32'd1);

    // Two words at P=4, then an underrun tail.
    fill_word(32'h03C0_0280);
    fill_word(32'hFFC0_EA80);
    end_fill(2);
    start_play(3);
    play_cycles(19, -1, 32'h0, -1);
    stop_and_flush();

    // P=2 single word, late refill during underrun, clear racing a new underrun.
    fill_word(32'h03C0_0280);
    end_fill(1);
    start_play(0);
    play_cycles(14, 7, 32'hFFC0_EA80, -1);
    play_cycles(6, -1, 32'h0, 1);
    stop_and_flush();

    // Overfill while stopped, then a dropped write while full during the first pop.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      check_output("fill_ready", 32'(wr_ready), (i < 16) ? 32'd1 : 32'd0);
      check_output("fill_count", 32'(level), 32'((i < 16) ? i : 16));
      w        = $urandom;
      wr_valid = 1'b1;
      wr_data  = w;
      if (i < 16) begin
        word_q.push_back(w);
        avail_q.push_back(-1000);
      end
    end
    @(negedge clk);
    check_output("full_level", 32'(level), 32'd16);
    check_output("full_ready", 32'(wr_ready), 32'd0);
    wr_data = $urandom;
    rd = int'($urandom_range(0, 4));
    start_play(rd);
    play_cycles(32 * per + 2, -1, 32'h0, -1);
    stop_and_flush();

    // Random streams with a random late write and a random underrun clear.
    for (int r = 0; r < 3; r++) begin
      n = int'($urandom_range(1, 5));
      for (int k = 0; k < n; k++) fill_word($urandom);
      end_fill(n);
      start_play(int'($urandom_range(0, 6)));
      total = (2 * n + 1) * per + 4;
      play_cycles(total, int'($urandom_range(0, total - 2)), $urandom, int'($urandom_range(0, total - 2)));
      stop_and_flush();
    end

    // Disable mid-play, flush, re-enable and wait in PRIME, then resume on a new word.
    for (int k = 0; k < 3; k++) fill_word($urandom);
    end_fill(3);
    start_play(int'($urandom_range(1, 5)));
    play_cycles(3 * per + 1, -1, 32'h0, -1);
    @(negedge clk);
    model_slot();
    enable = 1'b0;
    @(negedge clk);
    check_output("dis_busy", 32'(busy), 32'd0);
    check_output("dis_dclk", 32'(dclk), 32'd0);
    check_output("dis_data_held", 32'(dac_data), 32'(cur));
    check_output("dis_level", 32'(level), 32'(model_level(t)));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_output("flush_level", 32'(level), 32'd0);
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output("wait_busy", 32'(busy), 32'd1);
      check_output("wait_data", 32'(dac_data), 32'(cur));
      check_output("wait_dclk", 32'(dclk), 32'd0);
    end
    w = $urandom;
    wr_valid = 1'b1;
    wr_data  = w;
    @(negedge clk);
    wr_valid = 1'b0;
    check_output("resume_level", 32'(level), 32'd1);
    word_q.delete();
    avail_q.delete();
    word_q.push_back(w);
    avail_q.push_back(-1000);
    t = 0;
    half_b = 1'b0;
    play_cycles(2 * per + 3, -1, 32'h0, -1);
    stop_and_flush();

    // Asynchronous reset in the high half of a period.
    fill_word($urandom);
    fill_word($urandom);
    end_fill(2);
    start_play(int'($urandom_range(1, 6)));
    play_cycles(per + (per / 2) + 1, -1, 32'h0, -1);
    check_output("pre_reset_dclk", 32'(dclk), 32'd1);
    #3;
    rst    = 1'b1;
    enable = 1'b0;
    #1;
    check_output("arst_data", 32'(dac_data), 32'd0);
    check_output("arst_dclk", 32'(dclk), 32'd0);
    check_output("arst_underrun", 32'(underrun), 32'd0);
    check_output("arst_level", 32'(level), 32'd0);
    check_output("arst_busy", 32'(busy), 32'd0);
    check_output("arst_ready", 32'(wr_ready), 32'd1);
    #5;
    rst = 1'b0;
    @(negedge clk);
    check_output("post_rst_level", 32'(level), 32'd0);
    check_output("post_rst_busy", 32'(busy), 32'd0);
    check_output("post_rst_data", 32'(dac_data), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
